// File: rtl/dp_ram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
package dp_ram_arb_pkg;

   // Largest requester count the 3-bit grant index can address.
   localparam int MAX_REQ = 8;

   // One port's arbitration result.
   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } grant_t;

   // Round-robin successor of ptr among n requesters.
   function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int n);
      int nxt;
      nxt = int'(ptr) + 1;
      if (nxt >= n) nxt = 0;
      return 3'(nxt);
   endfunction

endpackage

// File: rtl/dp_ram_arbiter_rr_pick.sv
// Circular find-first-set: lowest-distance set bit of mask starting at start.
module rr_pick
   import dp_ram_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [2:0]   start,
   input  logic [N-1:0] mask,
   output grant_t       pick
);

   // Choose the set bit closest to start going upward with wrap.
   always_comb begin
      int best_d;
      int d;
      pick   = '0;
      best_d = MAX_REQ;
      d      = 0;
      for (int i = 0; i < N; i++) begin
         d = i - int'(start);
         if (d < 0) d = d + N;
         if (mask[i] && d < best_d) begin
            best_d     = d;
            pick.valid = 1'b1;
            pick.idx   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/dp_ram_async_read.sv
// Dual-port RAM: synchronous writes on both ports, combinational reads.
module dp_ram_async_read #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b
);

   logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

   // Commit writes from either port at the clock edge.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
   end

   assign dout_a = mem[addr_a];
   assign dout_b = mem[addr_b];

endmodule

// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter sharing one dual-port async-read RAM among N_REQ clients.
// Optional performance counters are compiled in with DP_RAM_ARB_PERF_CNT_EN.
module dp_ram_arbiter
   import dp_ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int N_REQ      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_we,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [N_REQ*DATA_WIDTH-1:0] rsp_rdata,
   output logic                        ram_we_a,
   output logic [ADDR_WIDTH-1:0]       ram_addr_a,
   output logic [DATA_WIDTH-1:0]       ram_din_a,
   input  logic [DATA_WIDTH-1:0]       ram_dout_a,
   output logic                        ram_we_b,
   output logic [ADDR_WIDTH-1:0]       ram_addr_b,
   output logic [DATA_WIDTH-1:0]       ram_din_b,
   input  logic [DATA_WIDTH-1:0]       ram_dout_b
`ifdef DP_RAM_ARB_PERF_CNT_EN
   ,
   output logic [N_REQ*16-1:0]         grant_cnt,
   output logic [15:0]                 conflict_cnt
`endif
);

   logic [2:0]            rr_ptr_reg;
   logic [2:0]            b_start;
   logic [N_REQ-1:0]      b_mask;
   grant_t                a_pick;
   grant_t                b_pick;
   logic                  a_we, b_we;
   logic [ADDR_WIDTH-1:0] a_addr, b_addr;
   logic [DATA_WIDTH-1:0] a_din, b_din;
   logic                  conflict;
   logic                  grant_a, grant_b;
   logic [N_REQ-1:0]      rsp_valid_reg;
   logic [N_REQ*DATA_WIDTH-1:0] rsp_rdata_reg;

   rr_pick #(.N(N_REQ)) u_pick_a (.start(rr_ptr_reg), .mask(req_valid), .pick(a_pick));
   rr_pick #(.N(N_REQ)) u_pick_b (.start(b_start),    .mask(b_mask),    .pick(b_pick));

   assign b_start = rr_next(a_pick.idx, N_REQ);

   // Port B searches the valid set with the A grantee removed.
   always_comb begin
      b_mask = req_valid;
      for (int i = 0; i < N_REQ; i++)
         if (a_pick.valid && int'(a_pick.idx) == i) b_mask[i] = 1'b0;
   end

   // Select the A grantee's request fields.
   always_comb begin
      a_we   = 1'b0;
      a_addr = '0;
      a_din  = '0;
      for (int i = 0; i < N_REQ; i++)
         if (int'(a_pick.idx) == i) begin
            a_we   = req_we[i];
            a_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            a_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
   end

   // Select the B candidate's request fields.
   always_comb begin
      b_we   = 1'b0;
      b_addr = '0;
      b_din  = '0;
      for (int i = 0; i < N_REQ; i++)
         if (int'(b_pick.idx) == i) begin
            b_we   = req_we[i];
            b_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            b_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
   end

   // Same address with any write on either side leaves B idle for this cycle.
   assign conflict = a_pick.valid && b_pick.valid && (a_addr == b_addr) && (a_we || b_we);
   assign grant_a  = !rst && a_pick.valid;
   assign grant_b  = !rst && b_pick.valid && !conflict;

   // Ready is purely a function of the current requests and pointer.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++)
         req_ready[i] = (grant_a && int'(a_pick.idx) == i) || (grant_b && int'(b_pick.idx) == i);
   end

   assign ram_we_a   = grant_a && a_we;
   assign ram_addr_a = grant_a ? a_addr : '0;
   assign ram_din_a  = grant_a ? a_din  : '0;
   assign ram_we_b   = grant_b && b_we;
   assign ram_addr_b = grant_b ? b_addr : '0;
   assign ram_din_b  = grant_b ? b_din  : '0;

   // Pointer moves past the last grantee of the cycle.
   always_ff @(posedge clk) begin
      if (rst)          rr_ptr_reg <= '0;
      else if (grant_b) rr_ptr_reg <= rr_next(b_pick.idx, N_REQ);
      else if (grant_a) rr_ptr_reg <= rr_next(a_pick.idx, N_REQ);
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
      logic hit_a, hit_b;
      assign hit_a = grant_a && !a_we && (int'(a_pick.idx) == gi);
      assign hit_b = grant_b && !b_we && (int'(b_pick.idx) == gi);

      // Capture read data of the granting port; pulse valid for one cycle.
      always_ff @(posedge clk) begin
         if (rst) begin
            rsp_valid_reg[gi]                         <= 1'b0;
            rsp_rdata_reg[gi*DATA_WIDTH +: DATA_WIDTH] <= '0;
         end else begin
            rsp_valid_reg[gi] <= hit_a || hit_b;
            if (hit_a)      rsp_rdata_reg[gi*DATA_WIDTH +: DATA_WIDTH] <= ram_dout_a;
            else if (hit_b) rsp_rdata_reg[gi*DATA_WIDTH +: DATA_WIDTH] <= ram_dout_b;
         end
      end
   end

   // A response pending while reset is asserted is dropped rather than shown.
   assign rsp_valid = rst ? '0 : rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;

`ifdef DP_RAM_ARB_PERF_CNT_EN
   logic [15:0] conflict_cnt_reg;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [15:0] grant_cnt_reg;

      // Saturating per-requester transfer count.
      always_ff @(posedge clk) begin
         if (rst)                                           grant_cnt_reg <= '0;
         else if (req_valid[gi] && req_ready[gi] && grant_cnt_reg != 16'hFFFF)
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
      end
      assign grant_cnt[gi*16 +: 16] = grant_cnt_reg;
   end

   // Saturating count of cycles where B was blocked by an address hazard.
   always_ff @(posedge clk) begin
      if (rst)                                       conflict_cnt_reg <= '0;
      else if (conflict && conflict_cnt_reg != 16'hFFFF) conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
   end
   assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter with an attached dp_ram_async_read, N_REQ=4.
module tb_dp_ram_arbiter;

   localparam int DW = 8;
   localparam int AW = 6;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata, rsp_rdata;
   logic            ram_we_a, ram_we_b;
   logic [AW-1:0]   ram_addr_a, ram_addr_b;
   logic [DW-1:0]   ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
`ifdef DP_RAM_ARB_PERF_CNT_EN
   logic [N*16-1:0] grant_cnt;
   logic [15:0]     conflict_cnt;
`endif

   int total = 0;
   int bad   = 0;

   dp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
      .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
`ifdef DP_RAM_ARB_PERF_CNT_EN
      , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
   );

   dp_ram_async_read #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
      .clk(clk),
      .we_a(ram_we_a), .addr_a(ram_addr_a), .din_a(ram_din_a), .dout_a(ram_dout_a),
      .we_b(ram_we_b), .addr_b(ram_addr_b), .din_b(ram_din_b), .dout_b(ram_dout_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  we;
      logic [23:0] addr;
      logic [3:0]  exp_ready;
      logic        exp_we_a;
      logic        exp_we_b;
   } vec_t;

   vec_t vecs[11];

   // reference-model state
   logic [7:0] mem_m   [64];
   bit         known_m [64];
   int         ptr_m;
   bit         pend_v  [4];
   bit         pend_we [4];
   logic [5:0] pend_a  [4];
   logic [7:0] pend_d  [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic set_req(input int i, input bit we, input logic [5:0] a, input logic [7:0] d);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   function automatic logic [23:0] mk_addr(input logic [5:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   // Model arbitration: list the pending requesters in round-robin order from
   // the pointer; A is the head of that list, B the next entry unless the pair
   // touches one address with a write involved.
   task automatic model_grant(output bit av, output int ai, output bit bv, output int bi);
      int order[$];
      av = 0; bv = 0; ai = 0; bi = 0;
      for (int k = 0; k < N; k++)
         if (pend_v[(ptr_m + k) % N]) order.push_back((ptr_m + k) % N);
      if (order.size() > 0) begin
         av = 1; ai = order[0];
      end
      if (order.size() > 1) begin
         bi = order[1];
         bv = !((pend_a[ai] == pend_a[bi]) && (pend_we[ai] || pend_we[bi]));
      end
   endtask

   initial begin
      int gcount[4];
      bit av, bv;
      int ai, bi;
      logic [3:0] exp_ready, exp_rv;
      logic [7:0] exp_rd [4];
      bit         exp_kn [4];

      vecs[0]  = '{4'b1111, 4'b0000, mk_addr(1, 2, 3, 4),    4'b0011, 1'b0, 1'b0};
      vecs[1]  = '{4'b0100, 4'b0100, mk_addr(0, 0, 9, 0),    4'b0100, 1'b1, 1'b0};
      vecs[2]  = '{4'b1010, 4'b1000, mk_addr(0, 5, 0, 6),    4'b1010, 1'b0, 1'b1};
      vecs[3]  = '{4'b0011, 4'b0011, mk_addr(7, 7, 0, 0),    4'b0001, 1'b1, 1'b0};
      vecs[4]  = '{4'b0011, 4'b0000, mk_addr(7, 7, 0, 0),    4'b0011, 1'b0, 1'b0};
      vecs[5]  = '{4'b0011, 4'b0010, mk_addr(7, 7, 0, 0),    4'b0001, 1'b0, 1'b0};
      vecs[6]  = '{4'b1001, 4'b0001, mk_addr(3, 0, 0, 4),    4'b1001, 1'b1, 1'b0};
      vecs[7]  = '{4'b0000, 4'b0000, mk_addr(0, 0, 0, 0),    4'b0000, 1'b0, 1'b0};
      vecs[8]  = '{4'b1100, 4'b1100, mk_addr(0, 0, 10, 11),  4'b1100, 1'b1, 1'b1};
      vecs[9]  = '{4'b0101, 4'b0001, mk_addr(12, 0, 12, 0),  4'b0001, 1'b1, 1'b0};
      vecs[10] = '{4'b1110, 4'b0010, mk_addr(0, 8, 8, 9),    4'b0010, 1'b1, 1'b0};

      // ---- reset with all requesters asking for writes ----
      rst = 1'b1;
      clear_req();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'(8'h30 + i), 8'(i));
      tick(); #1;
      chk("rst_ready_c1", 32'(req_ready), 32'h0);
      chk("rst_we_c1", 32'({ram_we_a, ram_we_b}), 32'h0);
      tick(); #1;
      chk("rst_ready_c2", 32'(req_ready), 32'h0);
      chk("rst_we_c2", 32'({ram_we_a, ram_we_b}), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("post_rst_rdata", rsp_rdata, 32'h0);
      chk("first_grant", 32'(req_ready), 32'b0011);
      $display("reset: ready=%b", req_ready);
      tick();
      clear_req();
      chk("write_no_rsp", 32'(rsp_valid), 32'h0);

      // ---- two writes to different addresses, then two reads ----
      set_req(0, 1'b1, 6'h01, 8'hAA);
      set_req(2, 1'b1, 6'h02, 8'hBB);
      #2;
      chk("wr_pair_ready", 32'(req_ready), 32'b0101);
      $display("wr pair: ready=%b", req_ready);
      tick();
      clear_req();
      set_req(1, 1'b0, 6'h01, 8'h00);
      set_req(3, 1'b0, 6'h02, 8'h00);
      #2;
      chk("rd_pair_ready", 32'(req_ready), 32'b1010);
      tick();
      clear_req();
      chk("rd_pair_rsp_valid", 32'(rsp_valid), 32'b1010);
      chk("rd_pair_rdata1", 32'(rsp_rdata[15:8]), 32'hAA);
      chk("rd_pair_rdata3", 32'(rsp_rdata[31:24]), 32'hBB);
      $display("rd pair: rsp_valid=%b rdata=%h", rsp_valid, rsp_rdata);

      // ---- same-address write hazard ----
      set_req(0, 1'b1, 6'h03, 8'h11);
      set_req(1, 1'b1, 6'h03, 8'h22);
      #2;
      chk("conflict_ready", 32'(req_ready), 32'b0001);
      chk("conflict_we_b", 32'(ram_we_b), 32'h0);
      tick();
`ifdef DP_RAM_ARB_PERF_CNT_EN
      chk("conflict_cnt", 32'(conflict_cnt), 32'd1);
`endif
      req_valid[0] = 1'b0;
      #2;
      chk("conflict_retry_ready", 32'(req_ready), 32'b0010);
      tick();
      clear_req();
      set_req(2, 1'b0, 6'h03, 8'h00);
      #2;
      chk("conflict_rd_ready", 32'(req_ready), 32'b0100);
      tick();
      clear_req();
      chk("conflict_rd_valid", 32'(rsp_valid), 32'b0100);
      chk("conflict_rd_data", 32'(rsp_rdata[23:16]), 32'h22);
      $display("conflict: final data=%h", rsp_rdata[23:16]);

      // ---- two reads of one address are both granted ----
      set_req(3, 1'b1, 6'h05, 8'h5A);
      #2;
      chk("wr05_ready", 32'(req_ready), 32'b1000);
      tick();
      clear_req();
      set_req(0, 1'b0, 6'h05, 8'h00);
      set_req(1, 1'b0, 6'h05, 8'h00);
      #2;
      chk("same_rd_ready", 32'(req_ready), 32'b0011);
      tick();
      clear_req();
      chk("same_rd_valid", 32'(rsp_valid), 32'b0011);
      chk("same_rd_data", 32'(rsp_rdata[15:0]), 32'h5A5A);
      $display("same rd: rdata=%h", rsp_rdata[15:0]);

      // ---- fairness with all four reading for 8 cycles ----
      for (int i = 0; i < N; i++) gcount[i] = 0;
      set_req(0, 1'b0, 6'h01, 8'h00);
      set_req(1, 1'b0, 6'h02, 8'h00);
      set_req(2, 1'b0, 6'h03, 8'h00);
      set_req(3, 1'b0, 6'h05, 8'h00);
      for (int c = 0; c < 8; c++) begin
         #2;
         exp_ready = (c % 2 == 0) ? 4'b1100 : 4'b0011;
         chk("rr_ready", 32'(req_ready), 32'(exp_ready));
         for (int i = 0; i < N; i++) if (req_ready[i]) gcount[i]++;
         $display("rr cycle %0d: ready=%b", c, req_ready);
         tick();
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(exp_ready));
      end
      clear_req();
      for (int i = 0; i < N; i++) chk("rr_count", 32'(gcount[i]), 32'd4);
      chk("rr_rdata", rsp_rdata, 32'h5A22BBAA);

      // ---- reset right after a read grant ----
      set_req(0, 1'b0, 6'h01, 8'h00);
      #2;
      chk("pre_rst_ready", 32'(req_ready), 32'b0001);
      tick();
      clear_req();
      rst = 1'b1;
      #1;
      chk("rst_drop_rsp", 32'(rsp_valid), 32'h0);
      tick();
      rst = 1'b0;
      chk("rst_drop_rsp2", 32'(rsp_valid), 32'h0);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 6'(i), 8'h00);
      #2;
      chk("rst_ptr_zero", 32'(req_ready), 32'b0011);
      $display("mid reset: ready=%b", req_ready);
      rst = 1'b1;
      clear_req();

      // ---- table vectors, each from a fresh reset (pointer 0) ----
      for (int v = 0; v < 11; v++) begin
         rst = 1'b1;
         clear_req();
         tick();
         rst = 1'b0;
         req_valid = vecs[v].valid;
         req_we    = vecs[v].we;
         req_addr  = vecs[v].addr;
         req_wdata = 32'hC3C3C3C3;
         #2;
         chk("vec_ready", 32'(req_ready), 32'(vecs[v].exp_ready));
         chk("vec_we", 32'({ram_we_a, ram_we_b}), 32'({vecs[v].exp_we_a, vecs[v].exp_we_b}));
         $display("vec %0d: valid=%b we=%b ready=%b", v, req_valid, req_we, req_ready);
      end

      // ---- randomized traffic against the reference model ----
      rst = 1'b1;
      clear_req();
      tick();
      tick();
      rst = 1'b0;
      ptr_m = 0;
      for (int a = 0; a < 64; a++) known_m[a] = 0;
      for (int i = 0; i < N; i++) pend_v[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
               pend_v[i]  = 1;
               pend_we[i] = 1'($urandom_range(0, 1));
               pend_a[i]  = 6'($urandom_range(0, 7));
               pend_d[i]  = 8'($urandom);
            end
         end
         clear_req();
         for (int i = 0; i < N; i++) if (pend_v[i]) set_req(i, pend_we[i], pend_a[i], pend_d[i]);
         #2;
         model_grant(av, ai, bv, bi);
         exp_ready = '0;
         if (av) exp_ready[ai] = 1'b1;
         if (bv) exp_ready[bi] = 1'b1;
         chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
         $display("rnd %0d: valid=%b we=%b ready=%b", c, req_valid, req_we, req_ready);
         exp_rv = '0;
         for (int i = 0; i < N; i++) begin
            exp_rd[i] = '0;
            exp_kn[i] = 0;
            if (exp_ready[i] && !pend_we[i]) begin
               exp_rv[i] = 1'b1;
               exp_rd[i] = mem_m[pend_a[i]];
               exp_kn[i] = known_m[pend_a[i]];
            end
         end
         for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
               if (pend_we[i]) begin
                  mem_m[pend_a[i]]   = pend_d[i];
                  known_m[pend_a[i]] = 1;
               end
               pend_v[i] = 0;
            end
         end
         if (bv)      ptr_m = (bi + 1) % N;
         else if (av) ptr_m = (ai + 1) % N;
         tick();
         chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         for (int i = 0; i < N; i++)
            if (exp_rv[i] && exp_kn[i]) chk("rnd_rdata", 32'(rsp_rdata[i*DW +: DW]), 32'(exp_rd[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
